// File: rtl/writeback_checker_if.sv
// Expectation, observation and status signals of the writeback checker.
// The master side is the stimulus / tile; the slave side is the checker.
interface writeback_checker_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                     exp_valid;
    logic                     exp_ready;
    logic [CH_W-1:0]          exp_ch;
    logic [ADDR_W-1:0]        exp_addr;
    logic [DATA_W-1:0]        exp_data;
    logic [DATA_W-1:0]        exp_mask;
    logic [NUM_CH-1:0]        obs_valid;
    logic [NUM_CH*ADDR_W-1:0] obs_addr;
    logic [NUM_CH*DATA_W-1:0] obs_data;
    logic                     finish;
    logic [15:0]              pass_count;
    logic                     fail;
    logic                     timeout;
    logic                     done;
    logic [15:0]              fail_index;
    logic [DATA_W-1:0]        fail_got;

    modport master (
        output exp_valid, exp_ch, exp_addr, exp_data, exp_mask,
        output obs_valid, obs_addr, obs_data, finish,
        input  exp_ready, pass_count, fail, timeout, done, fail_index, fail_got
    );

    modport slave (
        input  exp_valid, exp_ch, exp_addr, exp_data, exp_mask,
        input  obs_valid, obs_addr, obs_data, finish,
        output exp_ready, pass_count, fail, timeout, done, fail_index, fail_got
    );
endinterface

// File: rtl/writeback_checker.sv
// In-order scoreboard of expected RF/VRF/DMEM writes with per-head timeout,
// optional strict data checking and sticky pass/fail/done reporting.
module writeback_checker #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 20,
    parameter int unsigned STRICT  = 0
) (
    input logic                clock,
    input logic                reset,
    writeback_checker_if.slave bus
);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StRun, StPassDone, StFailed} state_e;

    state_e state_q, state_d;

    logic [CH_W-1:0]   fifo_ch   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [DATA_W-1:0] fifo_mask [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [WAIT_W-1:0] wait_q;
    logic              finish_pend_q;
    logic [15:0]       pass_q, fail_index_q;
    logic              fail_q, timeout_q;
    logic [DATA_W-1:0] fail_got_q;

    logic              in_run, head_valid, exp_ready, push, pop;
    logic              sel_valid, addr_hit, data_ok, match, mismatch;
    logic              strict_hit, timeout_hit;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign in_run     = (state_q == StRun);
    assign head_valid = (count_q != '0);
    assign exp_ready  = in_run && (count_q < CNT_W'(DEPTH));
    assign push       = bus.exp_valid && exp_ready;

    // Route the observed write of the head's channel onto one comparison port.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fifo_ch[rd_ptr_q] == CH_W'(c)) begin
                sel_valid = bus.obs_valid[c];
                sel_addr  = bus.obs_addr[c*ADDR_W +: ADDR_W];
                sel_data  = bus.obs_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign addr_hit    = head_valid && sel_valid && (sel_addr == fifo_addr[rd_ptr_q]);
    assign data_ok     = ((sel_data ^ fifo_data[rd_ptr_q]) & fifo_mask[rd_ptr_q]) == '0;
    assign match       = addr_hit && data_ok;
    assign mismatch    = addr_hit && !data_ok;
    assign pop         = in_run && match;
    assign strict_hit  = in_run && mismatch && (STRICT != 0);
    assign timeout_hit = in_run && head_valid && !match && (wait_q == WAIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (strict_hit || timeout_hit) begin
                    state_d = StFailed;
                end else if (!head_valid && finish_pend_q) begin
                    state_d = StPassDone;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        bus.exp_ready  = exp_ready;
        bus.done       = (state_q == StPassDone);
        bus.fail       = fail_q;
        bus.timeout    = timeout_q;
        bus.pass_count = pass_q;
        bus.fail_index = fail_index_q;
        bus.fail_got   = fail_got_q;
    end

    // Entry storage needs no reset: count_q alone defines which slots are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_ch[wr_ptr_q]   <= bus.exp_ch;
            fifo_addr[wr_ptr_q] <= bus.exp_addr;
            fifo_data[wr_ptr_q] <= bus.exp_data;
            fifo_mask[wr_ptr_q] <= bus.exp_mask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wait_q        <= '0;
            finish_pend_q <= 1'b0;
            pass_q        <= '0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_index_q  <= '0;
            fail_got_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (in_run) begin
                if (!head_valid || match) begin
                    wait_q <= '0;
                end else if (wait_q != WAIT_LAST) begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
                if (pop && pass_q != 16'hFFFF) begin
                    pass_q <= pass_q + 16'd1;
                end
                if (mismatch) begin
                    fail_got_q <= sel_data;
                end
                if (bus.finish) begin
                    finish_pend_q <= 1'b1;
                end
                if (strict_hit) begin
                    fail_q <= 1'b1;
                end
                if (timeout_hit) begin
                    timeout_q <= 1'b1;
                end
                if (strict_hit || timeout_hit) begin
                    fail_index_q <= pass_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_checker.sv
// Directed bench: a lax (STRICT=0) and a strict (STRICT=1) checker see identical stimulus.
module tb_writeback_checker;
    localparam logic [255:0] ONES  = {256{1'b1}};
    localparam logic [255:0] LOW32 = 256'hFFFF_FFFF;
    localparam logic [255:0] D1    = {8{32'h42C80000}};
    localparam logic [255:0] D2    = {8{32'h3F800000}} ^ 256'h1234_5678_9ABC_DEF0;
    localparam logic [255:0] D3    = 256'hCAFE_F00D;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         exp_valid;
    logic [1:0]   exp_ch;
    logic [11:0]  exp_addr;
    logic [255:0] exp_data, exp_mask;
    logic [2:0]   obs_valid;
    logic [35:0]  obs_addr;
    logic [767:0] obs_data;
    logic         finish;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    writeback_checker_if #(.DATA_W(256), .ADDR_W(12), .NUM_CH(3)) bus_lax ();
    writeback_checker_if #(.DATA_W(256), .ADDR_W(12), .NUM_CH(3)) bus_str ();

    assign bus_lax.exp_valid = exp_valid;
    assign bus_lax.exp_ch    = exp_ch;
    assign bus_lax.exp_addr  = exp_addr;
    assign bus_lax.exp_data  = exp_data;
    assign bus_lax.exp_mask  = exp_mask;
    assign bus_lax.obs_valid = obs_valid;
    assign bus_lax.obs_addr  = obs_addr;
    assign bus_lax.obs_data  = obs_data;
    assign bus_lax.finish    = finish;
    assign bus_str.exp_valid = exp_valid;
    assign bus_str.exp_ch    = exp_ch;
    assign bus_str.exp_addr  = exp_addr;
    assign bus_str.exp_data  = exp_data;
    assign bus_str.exp_mask  = exp_mask;
    assign bus_str.obs_valid = obs_valid;
    assign bus_str.obs_addr  = obs_addr;
    assign bus_str.obs_data  = obs_data;
    assign bus_str.finish    = finish;

    writeback_checker #(.STRICT(0)) u_lax (.clock(clock), .reset(reset), .bus(bus_lax));
    writeback_checker #(.STRICT(1)) u_str (.clock(clock), .reset(reset), .bus(bus_str));

    typedef struct {
        bit           rst;
        bit           push;
        logic [1:0]   ch;
        logic [11:0]  addr;
        logic [255:0] data;
        bit           obs;
        logic [1:0]   och;
        logic [11:0]  oaddr;
        logic [255:0] odata;
        bit           fin;
        logic [15:0]  e_pass;
        bit           e_ready;
        bit           e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit push, logic [1:0] ch, logic [11:0] addr,
                                logic [255:0] data, bit obs, logic [1:0] och,
                                logic [11:0] oaddr, logic [255:0] odata, bit fin,
                                logic [15:0] e_pass, bit e_ready, bit e_done);
        vec_t v;
        v.rst = rst; v.push = push; v.ch = ch; v.addr = addr; v.data = data;
        v.obs = obs; v.och = och; v.oaddr = oaddr; v.odata = odata; v.fin = fin;
        v.e_pass = e_pass; v.e_ready = e_ready; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk1(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] got,
                          input logic [255:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        exp_valid = 1'b0; exp_ch = '0; exp_addr = '0; exp_data = '0; exp_mask = '0;
        obs_valid = '0; obs_addr = '0; obs_data = '0; finish = 1'b0;
    endtask

    task automatic push_one(input logic [1:0] ch, input logic [11:0] addr,
                            input logic [255:0] data, input logic [255:0] mask);
        exp_valid = 1'b1; exp_ch = ch; exp_addr = addr; exp_data = data; exp_mask = mask;
    endtask

    task automatic obs_one(input logic [1:0] ch, input logic [11:0] addr,
                           input logic [255:0] data);
        obs_valid = '0; obs_addr = '0; obs_data = '0;
        obs_valid[ch] = 1'b1;
        obs_addr[int'(ch)*12 +: 12] = addr;
        obs_data[int'(ch)*256 +: 256] = data;
    endtask

    task automatic chk_reset(input string tag);
        chk16({tag, "_pass_lax"}, bus_lax.pass_count, 16'd0);
        chk16({tag, "_pass_str"}, bus_str.pass_count, 16'd0);
        chk1({tag, "_ready_lax"}, bus_lax.exp_ready, 1'b1);
        chk1({tag, "_ready_str"}, bus_str.exp_ready, 1'b1);
        chk1({tag, "_fail_lax"}, bus_lax.fail, 1'b0);
        chk1({tag, "_tmo_str"}, bus_str.timeout, 1'b0);
        chk1({tag, "_done_lax"}, bus_lax.done, 1'b0);
        chk16({tag, "_fidx_str"}, bus_str.fail_index, 16'd0);
        chk256({tag, "_got_lax"}, bus_lax.fail_got, 256'd0);
        chk256({tag, "_got_str"}, bus_str.fail_got, 256'd0);
    endtask

    // Reset is raised mid-cycle so the check proves it acts without a clock edge.
    task automatic do_reset(input string tag);
        clear_in();
        #2 reset = 1'b1;
        #1 chk_reset(tag);
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single VRF expectation, then three channels back to back.
        vecs.push_back(mk(1, 1, 2'd1, 12'd3, D1, 0, 2'd0, 12'd0, '0, 0, 16'd0, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 0, 2'd0, 12'd0, '0, 0, 16'd0, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 1, 2'd1, 12'd3, D1, 0, 16'd1, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 0, 2'd0, 12'd0, '0, 1, 16'd1, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 0, 2'd0, 12'd0, '0, 0, 16'd1, 0, 1));
        vecs.push_back(mk(1, 1, 2'd0, 12'd5, 256'h65, 0, 2'd0, 12'd0, '0, 0, 16'd0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 12'd4, D2, 0, 2'd0, 12'd0, '0, 0, 16'd0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd2, 12'h040, D3, 0, 2'd0, 12'd0, '0, 0, 16'd0, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 1, 2'd0, 12'd5, 256'h65, 0, 16'd1, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 1, 2'd1, 12'd4, D2, 0, 16'd2, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 1, 2'd2, 12'h040, D3, 0, 16'd3, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 0, 2'd0, 12'd0, '0, 1, 16'd3, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 12'd0, '0, 0, 2'd0, 12'd0, '0, 0, 16'd3, 0, 1));

        clear_in();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset($sformatf("v%0d_rst", i));
            clear_in();
            if (vecs[i].push) push_one(vecs[i].ch, vecs[i].addr, vecs[i].data, ONES);
            if (vecs[i].obs) obs_one(vecs[i].och, vecs[i].oaddr, vecs[i].odata);
            finish = vecs[i].fin;
            cyc();
            chk16($sformatf("v%0d_pass_lax", i), bus_lax.pass_count, vecs[i].e_pass);
            chk16($sformatf("v%0d_pass_str", i), bus_str.pass_count, vecs[i].e_pass);
            chk1($sformatf("v%0d_ready_lax", i), bus_lax.exp_ready, vecs[i].e_ready);
            chk1($sformatf("v%0d_ready_str", i), bus_str.exp_ready, vecs[i].e_ready);
            chk1($sformatf("v%0d_done_lax", i), bus_lax.done, vecs[i].e_done);
            chk1($sformatf("v%0d_done_str", i), bus_str.done, vecs[i].e_done);
            chk1($sformatf("v%0d_fail_str", i), bus_str.fail, 1'b0);
            chk1($sformatf("v%0d_tmo_lax", i), bus_lax.timeout, 1'b0);
        end

        // Head never written: timeout lands on the 20th edge after the push edge.
        do_reset("tmo_rst");
        push_one(2'd0, 12'd7, 256'd1, ONES);
        cyc();
        clear_in();
        repeat (19) cyc();
        chk1("tmo_early_lax", bus_lax.timeout, 1'b0);
        chk1("tmo_early_str", bus_str.timeout, 1'b0);
        cyc();
        chk1("tmo_lax", bus_lax.timeout, 1'b1);
        chk1("tmo_str", bus_str.timeout, 1'b1);
        chk1("tmo_fail_lax", bus_lax.fail, 1'b0);
        chk16("tmo_fidx_lax", bus_lax.fail_index, 16'd0);
        chk1("tmo_ready_lax", bus_lax.exp_ready, 1'b0);
        chk1("tmo_ready_str", bus_str.exp_ready, 1'b0);
        chk1("tmo_done_lax", bus_lax.done, 1'b0);

        // Write arrives while wait_cnt==TIMEOUT-1: the match wins.
        do_reset("late_rst");
        push_one(2'd0, 12'd7, 256'd1, ONES);
        cyc();
        clear_in();
        repeat (19) cyc();
        obs_one(2'd0, 12'd7, 256'd1);
        cyc();
        clear_in();
        chk16("late_pass_lax", bus_lax.pass_count, 16'd1);
        chk16("late_pass_str", bus_str.pass_count, 16'd1);
        chk1("late_tmo_lax", bus_lax.timeout, 1'b0);
        repeat (3) cyc();
        chk1("late_tmo_after", bus_lax.timeout, 1'b0);

        // Wrong masked DMEM data: strict fails, lax keeps polling then passes.
        do_reset("strict_rst");
        push_one(2'd0, 12'd1, 256'd5, ONES);
        cyc();
        push_one(2'd2, 12'h040, 256'h1234_5670, LOW32);
        cyc();
        clear_in();
        obs_one(2'd0, 12'd1, 256'd5);
        cyc();
        chk16("strict_pre_pass", bus_str.pass_count, 16'd1);
        obs_one(2'd2, 12'h040, 256'h1234_5671);
        cyc();
        clear_in();
        chk1("strict_fail_str", bus_str.fail, 1'b1);
        chk1("strict_tmo_str", bus_str.timeout, 1'b0);
        chk256("strict_got_str", bus_str.fail_got, 256'h1234_5671);
        chk16("strict_fidx_str", bus_str.fail_index, 16'd1);
        chk1("strict_ready_str", bus_str.exp_ready, 1'b0);
        chk1("strict_fail_lax", bus_lax.fail, 1'b0);
        chk256("strict_got_lax", bus_lax.fail_got, 256'h1234_5671);
        chk1("strict_ready_lax", bus_lax.exp_ready, 1'b1);
        cyc();
        obs_one(2'd2, 12'h040, {128'hFFFF_0000_DEAD, 128'h1234_5670});
        cyc();
        clear_in();
        chk16("poll_pass_lax", bus_lax.pass_count, 16'd2);
        chk16("poll_pass_str", bus_str.pass_count, 16'd1);
        chk1("poll_fail_str", bus_str.fail, 1'b1);
        chk1("poll_tmo_lax", bus_lax.timeout, 1'b0);

        // Reset in the middle of a wait clears everything without a clock edge.
        do_reset("mid_pre");
        push_one(2'd0, 12'd2, 256'd7, ONES);
        cyc();
        clear_in();
        obs_one(2'd0, 12'd2, 256'd7);
        cyc();
        clear_in();
        chk16("mid_pass_before", bus_lax.pass_count, 16'd1);
        push_one(2'd0, 12'd3, 256'd8, ONES);
        cyc();
        clear_in();
        repeat (3) cyc();
        #3 reset = 1'b1;
        #1 chk_reset("mid_async");
        cyc();
        reset = 1'b0;
        push_one(2'd1, 12'd9, D1, ONES);
        cyc();
        clear_in();
        obs_one(2'd1, 12'd9, D1);
        cyc();
        clear_in();
        chk16("mid_new_pass", bus_lax.pass_count, 16'd1);
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        cyc();
        chk1("mid_new_done_lax", bus_lax.done, 1'b1);
        chk1("mid_new_done_str", bus_str.done, 1'b1);

        // Full FIFO refuses a push; one pop reopens it; pointers then wrap.
        do_reset("full_rst");
        for (int i = 0; i < 8; i++) begin
            push_one(2'd0, 12'(i), 256'(i + 100), ONES);
            cyc();
        end
        chk1("full_ready_lax", bus_lax.exp_ready, 1'b0);
        chk1("full_ready_str", bus_str.exp_ready, 1'b0);
        push_one(2'd0, 12'd99, 256'd99, ONES);
        cyc();
        clear_in();
        chk1("full_ready_hold", bus_lax.exp_ready, 1'b0);
        obs_one(2'd0, 12'd0, 256'd100);
        cyc();
        chk1("full_ready_reopen", bus_lax.exp_ready, 1'b1);
        chk16("full_pass1", bus_lax.pass_count, 16'd1);
        for (int i = 1; i < 8; i++) begin
            obs_one(2'd0, 12'(i), 256'(i + 100));
            cyc();
            chk16($sformatf("drain%0d_pass", i), bus_str.pass_count, 16'(i + 1));
        end
        clear_in();
        push_one(2'd1, 12'd20, D2, ONES);
        cyc();
        clear_in();
        obs_one(2'd1, 12'd20, D2);
        cyc();
        clear_in();
        chk16("wrap_pass_lax", bus_lax.pass_count, 16'd9);
        chk16("wrap_pass_str", bus_str.pass_count, 16'd9);
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        chk1("wrap_done_early", bus_lax.done, 1'b0);
        cyc();
        chk1("wrap_done_lax", bus_lax.done, 1'b1);
        chk1("wrap_tmo_lax", bus_lax.timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
